// File: rtl/fpadd_writeback.sv
// Floating-point adder writeback queue.
//
// Takes results from the FP adder in its internal {exc[1:0], sign, exp, mant} form,
// converts them to IEEE-754 encoding at push time (SP results are NaN-boxed into 64 bits),
// buffers them in a DEPTH-entry FIFO and presents the head entry to the register file.
// Exception flags travel with each entry and are accumulated into the sticky FFLAGS
// register only when that entry retires.
//
// Parameters:
//   DEPTH  result FIFO entries (power of two, 2..16)
//   TAG_W  destination-register tag width
//
// Ports:
//   CLK, RST                 clock; synchronous active-high reset
//   IN_VALID / IN_READY      adder-side handshake
//   IN_RESULT[65:0]          adder result; SP results occupy [33:0]
//   IN_SP_DP                 1 = single precision, 0 = double precision
//   IN_INVALID/OVERFLOW/UNDERFLOW/INEXACT   adder exception flags
//   IN_TAG                   destination tag
//   OUT_VALID / OUT_READY    register-file-side handshake
//   OUT_DATA[63:0]           IEEE-754 result of head entry
//   OUT_TAG, OUT_SP_DP       head entry's tag and precision
//   FFLAGS[4:0]              sticky {NV, DZ, OF, UF, NX}; DZ is never set by an adder
//   FFLAGS_CLR               clear sticky flags (same-edge retirement still sets)
//   OCCUPANCY                number of valid entries
//
// Optional feature: define FPADD_WB_BYPASS_EN to forward a result combinationally to
// OUT_* when the FIFO is empty and the register file is ready; the entry is then
// retired immediately and never written into storage.

module fpadd_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [65:0]                IN_RESULT,
  input  logic                       IN_SP_DP,
  input  logic                       IN_INVALID,
  input  logic                       IN_OVERFLOW,
  input  logic                       IN_UNDERFLOW,
  input  logic                       IN_INEXACT,
  input  logic [TAG_W-1:0]           IN_TAG,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [63:0]                OUT_DATA,
  output logic [TAG_W-1:0]           OUT_TAG,
  output logic                       OUT_SP_DP,
  output logic [4:0]                 FFLAGS,
  input  logic                       FFLAGS_CLR,
  output logic [$clog2(DEPTH):0]     OCCUPANCY
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

  // Flag nibble order inside an entry: {NV, OF, UF, NX}.
  logic [63:0]      data_q  [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic             sp_dp_q [DEPTH];
  logic [3:0]       flags_q [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [4:0]       fflags_q, fflags_d;

  logic [63:0]      conv_data;
  logic [3:0]       in_flags;
  logic [3:0]       ret_flags;
  logic             fifo_empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             retire;

  // ---------------------------------------------------------------------------
  // Result conversion to IEEE-754
  // ---------------------------------------------------------------------------
  always_comb begin
    conv_data = 64'h0;
    if (IN_SP_DP) begin
      unique case (IN_RESULT[33:32])
        2'b00:   conv_data = {32'hFFFF_FFFF, IN_RESULT[31], 31'h0};
        2'b01:   conv_data = {32'hFFFF_FFFF, IN_RESULT[31:0]};
        2'b10:   conv_data = {32'hFFFF_FFFF, IN_RESULT[31], 8'hFF, 23'h0};
        default: conv_data = {32'hFFFF_FFFF, 32'h7FC0_0000};
      endcase
    end else begin
      unique case (IN_RESULT[65:64])
        2'b00:   conv_data = {IN_RESULT[63], 63'h0};
        2'b01:   conv_data = IN_RESULT[63:0];
        2'b10:   conv_data = {IN_RESULT[63], 11'h7FF, 52'h0};
        default: conv_data = 64'h7FF8_0000_0000_0000;
      endcase
    end
  end

  assign in_flags   = {IN_INVALID, IN_OVERFLOW, IN_UNDERFLOW, IN_INEXACT};
  assign fifo_empty = (occ_q == '0);

  // IN_READY depends on registered occupancy only, never on OUT_READY.
  assign IN_READY = (occ_q != OccFull);

  // ---------------------------------------------------------------------------
  // Output selection and handshake decode
  // ---------------------------------------------------------------------------
`ifdef FPADD_WB_BYPASS_EN
  assign bypass = fifo_empty && IN_VALID && OUT_READY;

  always_comb begin
    if (bypass) begin
      OUT_VALID = 1'b1;
      OUT_DATA  = conv_data;
      OUT_TAG   = IN_TAG;
      OUT_SP_DP = IN_SP_DP;
      ret_flags = in_flags;
    end else begin
      OUT_VALID = !fifo_empty;
      OUT_DATA  = data_q[rd_ptr_q];
      OUT_TAG   = tag_q[rd_ptr_q];
      OUT_SP_DP = sp_dp_q[rd_ptr_q];
      ret_flags = flags_q[rd_ptr_q];
    end
  end
`else
  assign bypass    = 1'b0;
  assign OUT_VALID = !fifo_empty;
  assign OUT_DATA  = data_q[rd_ptr_q];
  assign OUT_TAG   = tag_q[rd_ptr_q];
  assign OUT_SP_DP = sp_dp_q[rd_ptr_q];
  assign ret_flags = flags_q[rd_ptr_q];
`endif

  // A bypassed entry retires without touching storage or pointers.
  assign push   = IN_VALID && IN_READY && !bypass;
  assign pop    = OUT_VALID && OUT_READY && !bypass;
  assign retire = pop || bypass;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase

    // Clear first, then OR in the flags of the entry retiring on this edge.
    fflags_d = FFLAGS_CLR ? 5'b0 : fflags_q;
    if (retire) begin
      fflags_d = fflags_d | {ret_flags[3], 1'b0, ret_flags[2], ret_flags[1], ret_flags[0]};
    end
    fflags_d[3] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      fflags_q <= '0;
      // Storage is cleared so the idle head reads back as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        tag_q[i]   <= '0;
        sp_dp_q[i] <= 1'b0;
        flags_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      fflags_q <= fflags_d;
      if (push) begin
        data_q[wr_ptr_q]  <= conv_data;
        tag_q[wr_ptr_q]   <= IN_TAG;
        sp_dp_q[wr_ptr_q] <= IN_SP_DP;
        flags_q[wr_ptr_q] <= in_flags;
      end
    end
  end

  assign FFLAGS    = fflags_q;
  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_fpadd_writeback.sv
// Directed self-checking bench for fpadd_writeback (default build, DEPTH=4, TAG_W=5).
module tb_fpadd_writeback;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [65:0] IN_RESULT;
  logic        IN_SP_DP;
  logic        IN_INVALID;
  logic        IN_OVERFLOW;
  logic        IN_UNDERFLOW;
  logic        IN_INEXACT;
  logic [4:0]  IN_TAG;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] OUT_DATA;
  logic [4:0]  OUT_TAG;
  logic        OUT_SP_DP;
  logic [4:0]  FFLAGS;
  logic        FFLAGS_CLR;
  logic [2:0]  OCCUPANCY;

  int n_checks = 0;
  int n_errors = 0;

  fpadd_writeback #(
    .DEPTH(4),
    .TAG_W(5)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_RESULT   (IN_RESULT),
    .IN_SP_DP    (IN_SP_DP),
    .IN_INVALID  (IN_INVALID),
    .IN_OVERFLOW (IN_OVERFLOW),
    .IN_UNDERFLOW(IN_UNDERFLOW),
    .IN_INEXACT  (IN_INEXACT),
    .IN_TAG      (IN_TAG),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .OUT_TAG     (OUT_TAG),
    .OUT_SP_DP   (OUT_SP_DP),
    .FFLAGS      (FFLAGS),
    .FFLAGS_CLR  (FFLAGS_CLR),
    .OCCUPANCY   (OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // flags = {NV, OF, UF, NX}
  task automatic push(input logic sp, input logic [65:0] res, input logic [4:0] tag,
                      input logic [3:0] flags);
    IN_VALID  = 1'b1;
    IN_SP_DP  = sp;
    IN_RESULT = res;
    IN_TAG    = tag;
    {IN_INVALID, IN_OVERFLOW, IN_UNDERFLOW, IN_INEXACT} = flags;
    tick();
    IN_VALID  = 1'b0;
    {IN_INVALID, IN_OVERFLOW, IN_UNDERFLOW, IN_INEXACT} = 4'b0;
  endtask

  task automatic pop();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  // Conversion vectors: precision, raw result, expected IEEE output.
  logic        v_sp  [6];
  logic [65:0] v_res [6];
  logic [63:0] v_exp [6];

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_RESULT = '0; IN_SP_DP = 1'b0; IN_TAG = '0;
    {IN_INVALID, IN_OVERFLOW, IN_UNDERFLOW, IN_INEXACT} = 4'b0;
    OUT_READY = 1'b0; FFLAGS_CLR = 1'b0;
    tick(); tick();
    RST = 1'b0;

    // Reset state
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_in_ready",  64'(IN_READY),  64'd1);
    check("rst_occ",       64'(OCCUPANCY), 64'd0);
    check("rst_fflags",    64'(FFLAGS),    64'd0);
    check("rst_out_data",  OUT_DATA,       64'd0);
    check("rst_out_tag",   64'(OUT_TAG),   64'd0);

    // DP normal, one-cycle latency
    push(1'b0, {2'b01, 64'h3FF0_0000_0000_0000}, 5'd3, 4'b0);
    check("dp_out_valid", 64'(OUT_VALID), 64'd1);
    check("dp_out_data",  OUT_DATA,       64'h3FF0_0000_0000_0000);
    check("dp_out_tag",   64'(OUT_TAG),   64'd3);
    check("dp_out_sp_dp", 64'(OUT_SP_DP), 64'd0);
    check("dp_occ",       64'(OCCUPANCY), 64'd1);
    pop();
    check("dp_fflags",    64'(FFLAGS),    64'd0);
    check("dp_empty",     64'(OUT_VALID), 64'd0);

    // SP specials queued back to back
    push(1'b1, {32'h0, 2'b11, 1'b0, 31'h0}, 5'd7, 4'b0);
    push(1'b1, {32'h0, 2'b10, 1'b1, 31'h0}, 5'd8, 4'b0);
    check("sp_nan_data",  OUT_DATA,       64'hFFFF_FFFF_7FC0_0000);
    check("sp_nan_sp_dp", 64'(OUT_SP_DP), 64'd1);
    check("sp_nan_tag",   64'(OUT_TAG),   64'd7);
    pop();
    check("sp_ninf_data", OUT_DATA,       64'hFFFF_FFFF_FF80_0000);
    check("sp_ninf_tag",  64'(OUT_TAG),   64'd8);
    pop();

    // Conversion table
    v_sp[0] = 1'b0; v_res[0] = {2'b00, 1'b1, 63'h123};              v_exp[0] = 64'h8000_0000_0000_0000;
    v_sp[1] = 1'b0; v_res[1] = {2'b10, 1'b0, 63'h5};                v_exp[1] = 64'h7FF0_0000_0000_0000;
    v_sp[2] = 1'b0; v_res[2] = {2'b11, 64'h1234_5678_9ABC_DEF0};    v_exp[2] = 64'h7FF8_0000_0000_0000;
    v_sp[3] = 1'b1; v_res[3] = {32'hDEAD_BEEF, 2'b01, 32'h4049_0FDB}; v_exp[3] = 64'hFFFF_FFFF_4049_0FDB;
    v_sp[4] = 1'b1; v_res[4] = {32'h0, 2'b00, 32'h8000_1234};       v_exp[4] = 64'hFFFF_FFFF_8000_0000;
    v_sp[5] = 1'b0; v_res[5] = {2'b01, 64'hC000_0000_0000_0001};    v_exp[5] = 64'hC000_0000_0000_0001;
    for (int i = 0; i < 6; i++) begin
      push(v_sp[i], v_res[i], 5'(i + 16), 4'b0);
      check($sformatf("conv%0d_data", i), OUT_DATA, v_exp[i]);
      check($sformatf("conv%0d_tag", i), 64'(OUT_TAG), 64'(i + 16));
      pop();
    end

    // Backpressure: fill, stall, refused fifth push
    for (int i = 0; i < 4; i++) push(1'b0, {2'b01, 64'(64'hA0 + i)}, 5'(10 + i), 4'b0);
    check("full_in_ready", 64'(IN_READY),  64'd0);
    check("full_occ",      64'(OCCUPANCY), 64'd4);
    check("full_head",     OUT_DATA,       64'hA0);
    push(1'b0, {2'b01, 64'hEE}, 5'd31, 4'b0);
    check("full_refuse_occ", 64'(OCCUPANCY), 64'd4);
    check("full_hold_data",  OUT_DATA,       64'hA0);
    check("full_hold_tag",   64'(OUT_TAG),   64'd10);

    // Pop then push at full, then drain in order across the pointer wrap
    pop();
    check("fp_occ3", 64'(OCCUPANCY), 64'd3);
    push(1'b0, {2'b01, 64'hA4}, 5'd14, 4'b0);
    check("fp_occ4", 64'(OCCUPANCY), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d_data", i), OUT_DATA, 64'(64'hA0 + i));
      check($sformatf("drain%0d_tag", i), 64'(OUT_TAG), 64'(10 + i));
      pop();
    end
    check("drain_occ", 64'(OCCUPANCY), 64'd0);
    check("drain_fflags", 64'(FFLAGS), 64'd0);

    // Simultaneous push and pop keeps occupancy
    push(1'b0, {2'b01, 64'hB0}, 5'd1, 4'b0);
    IN_VALID = 1'b1; IN_RESULT = {2'b01, 64'hB1}; IN_TAG = 5'd2; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    check("pp_occ",  64'(OCCUPANCY), 64'd1);
    check("pp_data", OUT_DATA,       64'hB1);
    pop();

    // Flags
    push(1'b0, {2'b01, 64'h1}, 5'd4, 4'b0101);
    check("flags_not_queued", 64'(FFLAGS), 64'd0);
    pop();
    check("flags_of_nx", 64'(FFLAGS), 64'b00101);
    push(1'b0, {2'b01, 64'h2}, 5'd5, 4'b1000);
    FFLAGS_CLR = 1'b1;
    pop();
    FFLAGS_CLR = 1'b0;
    check("flags_clr_nv", 64'(FFLAGS), 64'b10000);
    push(1'b0, {2'b01, 64'h3}, 5'd6, 4'b0010);
    check("flags_queued_uf", 64'(FFLAGS), 64'b10000);
    FFLAGS_CLR = 1'b1;
    tick();
    FFLAGS_CLR = 1'b0;
    check("flags_clr_nopop", 64'(FFLAGS), 64'd0);
    pop();
    check("flags_uf", 64'(FFLAGS), 64'b00010);

    // Reset mid-stream, with a pop requested on the reset edge
    push(1'b0, {2'b01, 64'h11}, 5'd9, 4'b1111);
    push(1'b0, {2'b01, 64'h22}, 5'd9, 4'b1111);
    check("pre_rst_occ", 64'(OCCUPANCY), 64'd2);
    RST = 1'b1; OUT_READY = 1'b1;
    tick();
    RST = 1'b0; OUT_READY = 1'b0;
    check("mid_rst_occ",       64'(OCCUPANCY), 64'd0);
    check("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("mid_rst_fflags",    64'(FFLAGS),    64'd0);
    check("mid_rst_in_ready",  64'(IN_READY),  64'd1);
    check("mid_rst_out_data",  OUT_DATA,       64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
